param_mod_counter: RTL and testbench



---
 rtl/param_mod_counter_if.sv | 33 +++
 rtl/param_mod_counter.sv | 129 ++++++++++++
 tb/tb_param_mod_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/param_mod_counter_if.sv
// ----------------------------------------------------------------------------
// param_mod_counter_if
// Bundles the control inputs and status outputs of param_mod_counter.
//   master : drives en/up/load/load_val/limit/mode/clr_ovf, observes status
//   slave  : the counter side; receives controls, drives count/tc/wrap/ovf/done
// Parameter WIDTH must match the WIDTH of the attached counter.
// ----------------------------------------------------------------------------
interface param_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;
    logic             done;

    modport master (
        output en, up, load, load_val, limit, mode, clr_ovf,
        input  count, tc, wrap, ovf, done
    );

    modport slave (
        input  en, up, load, load_val, limit, mode, clr_ovf,
        output count, tc, wrap, ovf, done
    );
endinterface

// File: rtl/param_mod_counter.sv
// ----------------------------------------------------------------------------
// param_mod_counter
// Programmable-modulus up/down counter with wrap / saturate / one-shot
// end-of-range behaviour.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides every other input
//   bus  : param_mod_counter_if.slave
//          en, up, load, load_val, limit, mode, clr_ovf  (controls)
//          count, wrap, ovf, done (registered), tc (combinational)
// Parameters:
//   WIDTH   : counter / limit / load width in bits (>= 1)
//   RST_VAL : count value after reset
// ----------------------------------------------------------------------------
module param_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    param_mod_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             ovf_r;
    logic             done_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    logic             ovf_nxt_s;
    logic             done_nxt_s;
    logic             at_end_s;   // counter sits at the terminal for its direction
    mode_e            mode_s;

    assign mode_s = mode_e'(bus.mode);

    // Terminal-count detection, used both for tc and for the step decision.
    always_comb begin
        at_end_s = 1'b0;
        if (bus.up) begin
            at_end_s = (count_r >= bus.limit);
        end else begin
            at_end_s = (count_r == ZERO_C);
        end
    end

    // Next-state computation: load beats enable; the out-of-range clamp beats a normal step.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        ovf_nxt_s   = ovf_r & ~bus.clr_ovf;
        done_nxt_s  = done_r;

        if (bus.load) begin
            if (bus.load_val > bus.limit) begin
                count_nxt_s = bus.limit;
            end else begin
                count_nxt_s = bus.load_val;
            end
            done_nxt_s = 1'b0;
        end else if (bus.en && !done_r) begin
            if (count_r > bus.limit) begin
                // limit was lowered below the current count: pull back in range silently
                count_nxt_s = bus.limit;
            end else if (at_end_s) begin
                case (mode_s)
                    MODE_WRAP, MODE_WRAP_ALT: begin
                        if (bus.up) begin
                            count_nxt_s = ZERO_C;
                        end else begin
                            count_nxt_s = bus.limit;
                        end
                        wrap_nxt_s = 1'b1;
                        ovf_nxt_s  = 1'b1;   // a wrap outranks a simultaneous clear
                    end
                    MODE_SAT: begin
                        count_nxt_s = count_r;
                    end
                    MODE_ONESHOT: begin
                        done_nxt_s = 1'b1;
                    end
                    default: begin
                        count_nxt_s = count_r;
                    end
                endcase
            end else if (bus.up) begin
                count_nxt_s = count_r + ONE_C;
            end else begin
                count_nxt_s = count_r - ONE_C;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= RESET_C;
            wrap_r  <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
            ovf_r   <= ovf_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign bus.count = count_r;
    assign bus.tc    = at_end_s;
    assign bus.wrap  = wrap_r;
    assign bus.ovf   = ovf_r;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_param_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_param_mod_counter
// Directed checks of param_mod_counter (WIDTH=4, RST_VAL=0) with
// hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_param_mod_counter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    param_mod_counter_if #(.WIDTH(4)) bus ();

    param_mod_counter #(.WIDTH(4), .RST_VAL(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int c, input int w, input int o, input int d);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".wrap"},  int'(bus.wrap),  w);
        chk({tag, ".ovf"},   int'(bus.ovf),   o);
        chk({tag, ".done"},  int'(bus.done),  d);
    endtask

    // Directed stimulus sequence.
    initial begin
        int exp1 [7];
        int exp2 [7];
        n_pass  = 0;
        n_total = 0;
        exp1 = '{1, 2, 3, 4, 5, 0, 1};
        exp2 = '{1, 2, 3, 4, 5, 5, 5};

        rst = 1'b1;
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = 4'd0;
        bus.limit = 4'd5; bus.mode = 2'b00; bus.clr_ovf = 1'b0;
        #2;
        tick();
        chk_all("reset", 0, 0, 0, 0);

        // 1: wrap mode counting up to 5
        rst = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("t1.count%0d", i), int'(bus.count), exp1[i]);
            chk($sformatf("t1.wrap%0d", i), int'(bus.wrap), (i == 5) ? 1 : 0);
            chk($sformatf("t1.ovf%0d", i), int'(bus.ovf), (i >= 5) ? 1 : 0);
        end

        // 2: saturate mode
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = 2'b01;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("t2.count%0d", i), int'(bus.count), exp2[i]);
            chk($sformatf("t2.tc%0d", i), int'(bus.tc), (i >= 4) ? 1 : 0);
            chk($sformatf("t2.wrap%0d", i), int'(bus.wrap), 0);
            chk($sformatf("t2.ovf%0d", i), int'(bus.ovf), 0);
        end

        // 3: one-shot down from a loaded 3
        bus.mode = 2'b10; bus.up = 1'b0; bus.load = 1'b1; bus.load_val = 4'd3;
        tick();
        chk_all("t3.load", 3, 0, 0, 0);
        bus.load = 1'b0;
        tick(); chk_all("t3.s2", 2, 0, 0, 0);
        tick(); chk_all("t3.s1", 1, 0, 0, 0);
        tick(); chk_all("t3.s0", 0, 0, 0, 0);
        chk("t3.tc_down", int'(bus.tc), 1);
        tick(); chk_all("t3.done", 0, 0, 0, 1);
        bus.en = 1'b0; tick(); chk_all("t3.en0", 0, 0, 0, 1);
        bus.en = 1'b1; tick(); chk_all("t3.en1", 0, 0, 0, 1);
        bus.mode = 2'b00; tick(); chk_all("t3.modechg", 0, 0, 0, 1);
        bus.mode = 2'b10; bus.load = 1'b1; bus.load_val = 4'd2;
        tick(); chk_all("t3.reload", 2, 0, 0, 0);
        bus.load = 1'b0;
        tick(); chk_all("t3.r1", 1, 0, 0, 0);
        tick(); chk_all("t3.r0", 0, 0, 0, 0);
        tick(); chk_all("t3.rdone", 0, 0, 0, 1);

        // 4: down wrap with limit 9, clr_ovf against a simultaneous wrap
        bus.mode = 2'b00; bus.limit = 4'd9;
        bus.load = 1'b1; bus.load_val = 4'd0; bus.en = 1'b0;
        tick(); chk_all("t4.load0", 0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1;
        tick(); chk_all("t4.wrap1", 9, 1, 1, 0);
        bus.load = 1'b1; bus.en = 1'b0;
        tick(); chk_all("t4.reload0", 0, 0, 1, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.clr_ovf = 1'b1;
        tick(); chk_all("t4.wrap_clr", 9, 1, 1, 0);
        bus.en = 1'b0;
        tick(); chk_all("t4.clr", 9, 0, 0, 0);
        bus.clr_ovf = 1'b0;

        // 5: clamp after lowering limit, load clamp
        bus.limit = 4'd15; bus.load = 1'b1; bus.load_val = 4'd12;
        tick(); chk("t5.load12", int'(bus.count), 12);
        bus.load = 1'b0; bus.limit = 4'd7; bus.up = 1'b1;
        #1; chk("t5.tc_over", int'(bus.tc), 1);
        bus.en = 1'b1;
        tick(); chk_all("t5.clamp", 7, 0, 0, 0);
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd15;
        tick(); chk_all("t5.loadclamp", 7, 0, 0, 0);

        // 6: reset mid-count, then limit = 0
        bus.load_val = 4'd4; bus.limit = 4'd9;
        tick(); chk("t6.load4", int'(bus.count), 4);
        bus.load = 1'b0; bus.limit = 4'd4; bus.en = 1'b1;
        tick(); chk_all("t6.wrap", 0, 1, 1, 0);
        bus.load = 1'b1;
        tick(); chk_all("t6.load4b", 4, 0, 1, 0);
        rst = 1'b1; bus.en = 1'b1; bus.load = 1'b1;
        tick(); chk_all("t6.rst", 0, 0, 0, 0);
        rst = 1'b0; bus.load = 1'b0; bus.limit = 4'd0; bus.mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("t6.lim0_%0d", i), 0, 1, 1, 0);
        end
        bus.up = 1'b0;
        tick(); chk_all("t6.lim0_down", 0, 1, 1, 0);
        bus.en = 1'b0;
        tick(); chk_all("t6.lim0_idle", 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
